// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time an exclusive,
// multi-beat burst on a shared resource port. Arbitration scans upward from a
// rotating priority pointer. At the end of a burst the next winner is granted
// on the following edge, so there is no idle bubble between bursts.
module rr_burst_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int BURST_WIDTH    = 3,
  parameter int INDEX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_REQUESTERS-1:0]             request,
  input  logic [NUM_REQUESTERS*BURST_WIDTH-1:0] burst_len,
  input  logic                                  beat_ready,
  output logic                                  grant_valid,
  output logic [NUM_REQUESTERS-1:0]             grant_oh,
  output logic [INDEX_WIDTH-1:0]                grant_idx,
  output logic                                  last_beat
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   owner_q, owner_d;
  logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [BURST_WIDTH-1:0]   cnt_q, cnt_d;

  logic [INDEX_WIDTH-1:0]   scan_base;
  logic [INDEX_WIDTH-1:0]   probe;
  logic [INDEX_WIDTH-1:0]   win_idx;
  logic                     win_found;
  logic [BURST_WIDTH-1:0]   win_len;

  // Modulo-NUM_REQUESTERS increment; wraps at the last requester even when
  // NUM_REQUESTERS is not a power of two.
  function automatic logic [INDEX_WIDTH-1:0] wrap_inc(input logic [INDEX_WIDTH-1:0] v);
    if (v >= LAST_IDX) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Extract the beats-1 field belonging to requester idx.
  function automatic logic [BURST_WIDTH-1:0] len_field(
    input logic [NUM_REQUESTERS*BURST_WIDTH-1:0] lens,
    input logic [INDEX_WIDTH-1:0]                idx
  );
    return lens[int'(idx)*BURST_WIDTH +: BURST_WIDTH];
  endfunction

  // Priority scan: start at the pointer (or just past the retiring owner while
  // busy, which puts that owner last) and take the first active request.
  always_comb begin
    scan_base = (state_q == BUSY) ? wrap_inc(owner_q) : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    probe     = scan_base;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!win_found && request[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
      probe = wrap_inc(probe);
    end
    win_len = len_field(burst_len, win_idx);
  end

  // Next-state logic: grant from IDLE, count beats, hand over or go idle at burst end.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          owner_d = win_idx;
          cnt_d   = win_len;
        end
      end
      BUSY: begin
        if (beat_ready) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            ptr_d = wrap_inc(owner_q);
            if (win_found) begin
              owner_d = win_idx;
              cnt_d   = win_len;
            end else begin
              state_d = IDLE;
              owner_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any burst in progress immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded purely from registers; index and one-hot always agree.
  always_comb begin
    grant_valid = (state_q == BUSY);
    grant_idx   = grant_valid ? owner_q : '0;
    last_beat   = grant_valid && (cnt_q == '0);
    grant_oh    = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      grant_oh[i] = grant_valid && (owner_q == INDEX_WIDTH'(i));
    end
  end

endmodule
